ila_buffer_streamer: RTL

//  Downstream reader of the ILA sample buffer: on a start command it walks buffer entries,

---
 rtl/ila_buffer_streamer_pkg.sv | 23 ++
 rtl/ila_stream_oreg.sv | 56 +++++
 rtl/ila_buffer_streamer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ila_buffer_streamer_pkg.sv
// rtl/ila_buffer_streamer_pkg.sv - shared state encoding and sizing helpers for the ILA buffer streamer
package ila_buffer_streamer_pkg;

  typedef enum logic [2:0] {
    STR_IDLE = 3'd0,
    STR_ADDR = 3'd1,
    STR_WAIT = 3'd2,
    STR_HOLD = 3'd3,
    STR_DONE = 3'd4
  } str_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Select width never collapses to zero so a single-slice signal still has a port.
  function automatic int calc_sel_w(input int data_w, input int signal_w);
    int n;
    n = ceil_div(signal_w, data_w);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ila_stream_oreg.sv
// rtl/ila_stream_oreg.sv - stream output holding register (data/valid/last) with load, clear and ready
module ila_stream_oreg #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              last_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  // Clear beats load so an abort can never leave a fresh word on the stream.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (clear_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (cke_i) begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/ila_buffer_streamer.sv
// rtl/ila_buffer_streamer.sv - walks ILA buffer entries and streams each slice with valid/ready/last
module ila_buffer_streamer
  import ila_buffer_streamer_pkg::*;
#(
  parameter int  DATA_W   = 32,
  parameter int  SIGNAL_W = 40,
  parameter int  BUFFER_W = 4,
  parameter int  READ_LAT = 2,
  localparam int N_PARTS  = ceil_div(SIGNAL_W, DATA_W),
  localparam int SEL_W    = calc_sel_w(DATA_W, SIGNAL_W)
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_n_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [BUFFER_W-1:0] first_i,
  input  logic [BUFFER_W-1:0] count_i,
  input  logic [BUFFER_W-1:0] samples_i,
  output logic [BUFFER_W-1:0] index_o,
  output logic [SEL_W-1:0]    value_select_o,
  input  logic [DATA_W-1:0]   value_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                last_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int                WAIT_W    = $clog2(READ_LAT + 1);
  localparam logic [SEL_W-1:0]  LAST_PART = SEL_W'(N_PARTS - 1);
  localparam logic [BUFFER_W-1:0] ONE_B   = BUFFER_W'(1);

  str_state_e          state_q, state_d;
  logic [BUFFER_W-1:0] idx_q, idx_d;
  logic [BUFFER_W-1:0] rem_q, rem_d;
  logic [BUFFER_W-1:0] index_q, index_d;
  logic [SEL_W-1:0]    part_q, part_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                oreg_load, oreg_clear, oreg_last, handshake;
  logic [BUFFER_W-1:0] start_rem;

  assign handshake = valid_o & ready_i;
  assign start_rem = (count_i != '0) ? count_i : samples_i;
  assign oreg_last = (part_q == LAST_PART) && (rem_q == ONE_B);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    index_d    = index_q;
    part_d     = part_q;
    sel_d      = sel_q;
    wait_d     = wait_q;
    done_d     = 1'b0;
    oreg_load  = 1'b0;
    oreg_clear = 1'b0;
    case (state_q)
      STR_IDLE: begin
        if (start_i && !abort_i) begin
          idx_d  = first_i;
          rem_d  = start_rem;
          part_d = '0;
          if (start_rem == '0) begin
            state_d = STR_DONE;
          end else begin
            index_d = first_i;
            sel_d   = '0;
            state_d = STR_ADDR;
          end
        end
      end
      STR_ADDR: begin
        wait_d  = WAIT_W'(READ_LAT);
        state_d = STR_WAIT;
      end
      STR_WAIT: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q == WAIT_W'(1)) begin
          oreg_load = 1'b1;
          state_d   = STR_HOLD;
        end
      end
      STR_HOLD: begin
        if (handshake) begin
          if (part_q != LAST_PART) begin
            part_d  = part_q + SEL_W'(1);
            sel_d   = part_d;
            index_d = idx_q;
            state_d = STR_ADDR;
          end else begin
            part_d = '0;
            idx_d  = idx_q + ONE_B;
            rem_d  = rem_q - ONE_B;
            if (rem_q == ONE_B) begin
              state_d = STR_DONE;
            end else begin
              index_d = idx_d;
              sel_d   = '0;
              state_d = STR_ADDR;
            end
          end
        end
      end
      STR_DONE: begin
        done_d  = 1'b1;
        state_d = STR_IDLE;
      end
      default: state_d = STR_IDLE;
    endcase
    // Abort wins over a same-cycle handshake and drops any held word.
    if (abort_i && (state_q inside {STR_ADDR, STR_WAIT, STR_HOLD})) begin
      state_d    = STR_DONE;
      oreg_load  = 1'b0;
      oreg_clear = 1'b1;
    end
    busy_d = (state_d != STR_IDLE);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= STR_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      index_q <= '0;
      part_q  <= '0;
      sel_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      index_q <= index_d;
      part_q  <= part_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ila_stream_oreg #(.DATA_W(DATA_W)) u_oreg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .clear_i  (oreg_clear),
    .load_i   (oreg_load),
    .data_i   (value_i),
    .last_i   (oreg_last),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .last_o   (last_o)
  );

  assign index_o        = index_q;
  assign value_select_o = sel_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule
